// File: rtl/hdlc_tx_channel.sv
// hdlc_tx_channel
//   Transmit side of the HDLC link. Payload bytes enter through a one-byte
//   valid/ready holding register and go out LSB first at one bit per Clk.
//   Each frame is wrapped in opening and closing flags. A zero is inserted
//   after every five consecutive data ones. The abort pattern is sent when
//   requested, or when the holding register is empty at a byte boundary.
//
// Ports
//   Clk, Rst        clock, asynchronous active-low reset
//   TxEN            channel enable; low forces IDLE and flushes the holding reg
//   TxData/TxLast   payload byte and end-of-frame marker, qualified by TxValid
//   TxValid/TxReady byte handshake into the holding register
//   TxAbort         abort request (honoured in OPEN_FLAG and DATA)
//   Tx              registered serial line bit
//   Busy            state is not IDLE
//   FrameDone       pulse: closing flag completed
//   Aborted         pulse: abort pattern completed
//   Underrun        pulse: abort entered because the holding register was empty
module hdlc_tx_channel #(
    parameter logic [7:0] FLAG  = 8'h7E,
    parameter logic [7:0] ABORT = 8'hFE
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TxEN,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    input  logic       TxLast,
    output logic       TxReady,
    input  logic       TxAbort,
    output logic       Tx,
    output logic       Busy,
    output logic       FrameDone,
    output logic       Aborted,
    output logic       Underrun
);

    typedef enum logic [2:0] {
        StIdle,
        StOpenFlag,
        StData,
        StCloseFlag,
        StAbort
    } txState_e;

    txState_e   state, stateNxt;
    logic [2:0] bitIdx, bitIdxNxt;   // index of the bit currently on Tx
    logic       stuff, stuffNxt;     // current Tx bit is an inserted zero
    logic [2:0] onesCnt, onesNxt;    // consecutive data ones already sent
    logic [7:0] shReg;               // byte being serialized
    logic       curLast;             // TxLast of the byte being serialized
    logic [7:0] holdData;
    logic       holdLast;
    logic       holdFull;
    logic       txReg, txNxt;
    logic       frameDoneNxt, abortedNxt, underrunNxt;
    logic       loadHold, flushHold;
    logic       advance, byteEnd;
    logic [2:0] idxInc;
    logic [2:0] onesInc;
    logic       accept;

    assign TxReady = TxEN && !holdFull && (state != StAbort);
    assign accept  = TxValid && TxReady;
    assign Busy    = (state != StIdle);
    assign Tx      = txReg;

    always_comb begin
        stateNxt     = state;
        bitIdxNxt    = bitIdx;
        stuffNxt     = 1'b0;
        onesNxt      = onesCnt;
        txNxt        = txReg;
        frameDoneNxt = 1'b0;
        abortedNxt   = 1'b0;
        underrunNxt  = 1'b0;
        loadHold     = 1'b0;
        flushHold    = 1'b0;
        advance      = 1'b0;
        byteEnd      = 1'b0;
        idxInc       = bitIdx + 3'd1;
        onesInc      = shReg[bitIdx] ? onesCnt + 3'd1 : 3'd0;

        case (state)
            StIdle: begin
                txNxt = 1'b1;
                if (holdFull) begin
                    stateNxt  = StOpenFlag;
                    bitIdxNxt = 3'd0;
                    txNxt     = FLAG[0];
                    onesNxt   = 3'd0;
                end
            end
            StOpenFlag: begin
                if (bitIdx == 3'd7) begin
                    byteEnd = 1'b1;
                end else begin
                    bitIdxNxt = idxInc;
                    txNxt     = FLAG[idxInc];
                end
            end
            StData: begin
                // After an inserted zero the bit index resumes where it left off.
                if (stuff) begin
                    advance = 1'b1;
                end else if (onesInc == 3'd5) begin
                    stuffNxt = 1'b1;
                    txNxt    = 1'b0;
                    onesNxt  = 3'd0;
                end else begin
                    onesNxt = onesInc;
                    advance = 1'b1;
                end
            end
            StCloseFlag: begin
                if (bitIdx == 3'd7) begin
                    frameDoneNxt = 1'b1;
                    if (holdFull) begin
                        // Back-to-back frames get their own opening flag.
                        stateNxt  = StOpenFlag;
                        bitIdxNxt = 3'd0;
                        txNxt     = FLAG[0];
                        onesNxt   = 3'd0;
                    end else begin
                        stateNxt = StIdle;
                        txNxt    = 1'b1;
                    end
                end else begin
                    bitIdxNxt = idxInc;
                    txNxt     = FLAG[idxInc];
                end
            end
            StAbort: begin
                if (bitIdx == 3'd7) begin
                    abortedNxt = 1'b1;
                    stateNxt   = StIdle;
                    txNxt      = 1'b1;
                end else begin
                    bitIdxNxt = idxInc;
                    txNxt     = ABORT[idxInc];
                end
            end
            default: begin
                stateNxt = StIdle;
                txNxt    = 1'b1;
            end
        endcase

        if (advance) begin
            if (bitIdx == 3'd7) begin
                byteEnd = 1'b1;
            end else begin
                bitIdxNxt = idxInc;
                txNxt     = shReg[idxInc];
            end
        end

        // Byte boundary: continue with the held byte, close, or underrun.
        if (byteEnd) begin
            bitIdxNxt = 3'd0;
            if (holdFull) begin
                stateNxt = StData;
                txNxt    = holdData[0];
                loadHold = 1'b1;
            end else if (state == StData && curLast) begin
                stateNxt = StCloseFlag;
                txNxt    = FLAG[0];
                onesNxt  = 3'd0;
            end else begin
                stateNxt    = StAbort;
                txNxt       = ABORT[0];
                onesNxt     = 3'd0;
                underrunNxt = 1'b1;
                flushHold   = 1'b1;
            end
        end

        // An abort request wins over the byte-boundary decision but keeps any
        // underrun indication raised on the same edge.
        if (TxAbort && (state == StOpenFlag || state == StData)) begin
            stateNxt  = StAbort;
            bitIdxNxt = 3'd0;
            stuffNxt  = 1'b0;
            txNxt     = ABORT[0];
            onesNxt   = 3'd0;
            loadHold  = 1'b0;
            flushHold = 1'b1;
        end

        // Disable drops everything silently.
        if (!TxEN) begin
            stateNxt     = StIdle;
            bitIdxNxt    = 3'd0;
            stuffNxt     = 1'b0;
            onesNxt      = 3'd0;
            txNxt        = 1'b1;
            loadHold     = 1'b0;
            flushHold    = 1'b1;
            frameDoneNxt = 1'b0;
            abortedNxt   = 1'b0;
            underrunNxt  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= StIdle;
            bitIdx    <= 3'd0;
            stuff     <= 1'b0;
            onesCnt   <= 3'd0;
            shReg     <= 8'd0;
            curLast   <= 1'b0;
            holdData  <= 8'd0;
            holdLast  <= 1'b0;
            holdFull  <= 1'b0;
            txReg     <= 1'b1;
            FrameDone <= 1'b0;
            Aborted   <= 1'b0;
            Underrun  <= 1'b0;
        end else begin
            state     <= stateNxt;
            bitIdx    <= bitIdxNxt;
            stuff     <= stuffNxt;
            onesCnt   <= onesNxt;
            txReg     <= txNxt;
            FrameDone <= frameDoneNxt;
            Aborted   <= abortedNxt;
            Underrun  <= underrunNxt;
            if (loadHold) begin
                shReg   <= holdData;
                curLast <= holdLast;
            end
            if (accept) begin
                holdData <= TxData;
                holdLast <= TxLast;
            end
            if (flushHold || loadHold) begin
                holdFull <= 1'b0;
            end else if (accept) begin
                holdFull <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// Bench for hdlc_tx_channel: table of single/double-byte frames with
// hand-derived line bits, hand sequences for underrun/abort/enable/reset,
// and random frames checked against a bit-string model of the framing rules.
module tb_hdlc_tx_channel;

    logic       Clk = 1'b0;
    logic       Rst, TxEN, TxValid, TxLast, TxAbort;
    logic [7:0] TxData;
    logic       TxReady, Tx, Busy, FrameDone, Aborted, Underrun;

    always #5 Clk = ~Clk;

    hdlc_tx_channel dut (
        .Clk(Clk), .Rst(Rst), .TxEN(TxEN), .TxData(TxData), .TxValid(TxValid),
        .TxLast(TxLast), .TxReady(TxReady), .TxAbort(TxAbort), .Tx(Tx),
        .Busy(Busy), .FrameDone(FrameDone), .Aborted(Aborted), .Underrun(Underrun)
    );

    int nPass  = 0;
    int nTotal = 0;

    string flagS  = "01111110";
    string abortS = "01111111";

    task automatic chk(input string name, input int act, input int exp);
        nTotal++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chkStr(input string name, input string act, input string exp);
        nTotal++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %s, expected %s", name, act, exp);
    endtask

    // Reference: flags around the zero-stuffed concatenation of data bits.
    function automatic string modelFrame(input logic [7:0] b[$]);
        string s;
        int    ones;
        s = flagS;
        ones = 0;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                s = {s, b[i][k] ? "1" : "0"};
                ones = b[i][k] ? ones + 1 : 0;
                if (ones == 5) begin
                    s = {s, "0"};
                    ones = 0;
                end
            end
        end
        return {s, flagS};
    endfunction

    // Byte feeder: presents the queue head, drops it on acceptance.
    typedef struct {
        logic [7:0] d;
        logic       l;
    } feedT;
    feedT feedQ[$];
    int   gapLeft  = 0;
    bit   randGaps = 0;

    task automatic tick();
        bit acc;
        if (!TxValid && feedQ.size() > 0) begin
            if (gapLeft > 0) gapLeft--;
            else begin
                TxValid = 1'b1;
                TxData  = feedQ[0].d;
                TxLast  = feedQ[0].l;
            end
        end
        #1;
        acc = TxValid && TxReady;
        @(posedge Clk);
        #1;
        if (acc) begin
            feedQ.delete(0);
            TxValid = 1'b0;
            gapLeft = randGaps ? int'($urandom_range(0, 3)) : 0;
        end
    endtask

    // Records Tx while Busy, then the outputs on the first idle cycle.
    string capStr;
    int    capUrCnt, capUrIdx, capFdCnt, capAbCnt;
    bit    endTx, endFd, endAb, endReady;

    task automatic capture(input int abortAt, input int enDropAt);
        bit started;
        bit done;
        int k;
        started = 0; done = 0;
        capStr = ""; capUrCnt = 0; capUrIdx = -1; capFdCnt = 0; capAbCnt = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!started && !Busy) continue;
            started = 1;
            if (Busy) begin
                k = capStr.len();
                capStr = {capStr, Tx ? "1" : "0"};
                if (Underrun) begin capUrCnt++; capUrIdx = k; end
                if (FrameDone) capFdCnt++;
                if (Aborted) capAbCnt++;
                TxAbort = (k == abortAt);
                if (k == enDropAt) TxEN = 1'b0;
            end else begin
                endTx = Tx; endFd = FrameDone; endAb = Aborted; endReady = TxReady;
                TxAbort = 1'b0;
                TxEN = 1'b1;
                done = 1;
                break;
            end
        end
        if (!done) begin
            nTotal++;
            $display("FAIL capture timeout: got started=%0d len=%0d, expected frame end", started, capStr.len());
            TxAbort = 1'b0;
            TxEN = 1'b1;
        end
    endtask

    typedef struct {
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        int         len;
        logic [31:0] bits;   // data field as sent, bit 0 first
    } vecT;
    vecT tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp, s;
        int    fd;
        logic [7:0] bq[$];
        int    n;

        tbl[0] = '{1, 8'h01, 8'h00, 8,  32'h00001};
        tbl[1] = '{1, 8'hFF, 8'h00, 9,  32'h001DF};
        tbl[2] = '{1, 8'h7E, 8'h00, 9,  32'h000BE};
        tbl[3] = '{1, 8'hF8, 8'h00, 9,  32'h000F8};  // insertion after final bit
        tbl[4] = '{1, 8'h00, 8'h00, 8,  32'h00000};
        tbl[5] = '{1, 8'hA5, 8'h00, 8,  32'h000A5};
        tbl[6] = '{2, 8'hFF, 8'hFF, 19, 32'h5F7DF};  // ones run spans bytes
        tbl[7] = '{2, 8'hF0, 8'h01, 17, 32'h001F0};

        Rst = 1'b0; TxEN = 1'b1; TxValid = 1'b0; TxLast = 1'b0; TxAbort = 1'b0; TxData = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset Tx", Tx, 1);
        chk("reset Busy", Busy, 0);
        chk("reset FrameDone", FrameDone, 0);
        chk("reset Aborted", Aborted, 0);
        chk("reset Underrun", Underrun, 0);
        chk("reset TxReady", TxReady, 1);
        Rst = 1'b1;

        // Table-driven single frames.
        for (int i = 0; i < 8; i++) begin
            feedQ.push_back('{tbl[i].d0, tbl[i].n == 1});
            if (tbl[i].n == 2) feedQ.push_back('{tbl[i].d1, 1'b1});
            capture(-1, -1);
            s = "";
            for (int k = 0; k < tbl[i].len; k++) s = {s, tbl[i].bits[k] ? "1" : "0"};
            exp = {flagS, s, flagS};
            chkStr($sformatf("tbl%0d stream", i), capStr, exp);
            chk($sformatf("tbl%0d FrameDone at end", i), endFd, 1);
            chk($sformatf("tbl%0d FrameDone during frame", i), capFdCnt, 0);
            tick();
            chk($sformatf("tbl%0d FrameDone one cycle", i), FrameDone, 0);
            chk($sformatf("tbl%0d idle Tx", i), Tx, 1);
        end

        // Underrun: lone byte without TxLast.
        feedQ.push_back('{8'h55, 1'b0});
        capture(-1, -1);
        chkStr("underrun stream", capStr, {flagS, "10101010", abortS});
        chk("underrun pulses", capUrCnt, 1);
        chk("underrun at abort entry", capUrIdx, 16);
        chk("underrun Aborted at end", endAb, 1);
        chk("underrun no FrameDone", endFd + capFdCnt, 0);

        // TxAbort during third data bit with a second byte held.
        feedQ.push_back('{8'h00, 1'b0});
        feedQ.push_back('{8'h00, 1'b0});
        capture(10, -1);
        chkStr("abort stream", capStr, {flagS, "000", abortS});
        chk("abort Aborted at end", endAb, 1);
        chk("abort no Underrun", capUrCnt, 0);
        chk("abort TxReady after", endReady, 1);
        repeat (3) tick();
        chk("abort hold flushed", Busy, 0);

        // TxAbort together with underrun at the last data bit.
        feedQ.push_back('{8'h00, 1'b0});
        capture(15, -1);
        chkStr("abort+underrun stream", capStr, {flagS, "00000000", abortS});
        chk("abort+underrun Underrun", capUrCnt, 1);
        chk("abort+underrun Aborted early", capAbCnt, 0);
        chk("abort+underrun Aborted end", endAb, 1);
        tick();
        chk("abort+underrun single Aborted", Aborted, 0);

        // TxEN low mid-frame.
        feedQ.push_back('{8'hA5, 1'b1});
        capture(-1, 12);
        chkStr("enable drop stream", capStr, {flagS, "10100"});
        chk("enable drop Tx", endTx, 1);
        chk("enable drop pulses", endFd + endAb, 0);
        fd = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            fd += FrameDone + Busy;
        end
        chk("enable drop stays idle", fd, 0);

        // Asynchronous reset mid-data, then a clean frame.
        feedQ.push_back('{8'hFF, 1'b1});
        repeat (12) tick();
        chk("pre-reset Busy", Busy, 1);
        #2 Rst = 1'b0;
        #1;
        chk("async reset Tx", Tx, 1);
        chk("async reset Busy", Busy, 0);
        chk("async reset pulses", FrameDone + Aborted + Underrun, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        feedQ.push_back('{8'h01, 1'b1});
        capture(-1, -1);
        chkStr("post-reset stream", capStr, {flagS, "10000000", flagS});
        chk("post-reset FrameDone", endFd, 1);

        // Random frames with random handshake gaps.
        randGaps = 1;
        for (int f = 0; f < 25; f++) begin
            bq.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                bq.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
                feedQ.push_back('{bq[i], i == n - 1});
            end
            capture(-1, -1);
            chkStr($sformatf("rand%0d stream", f), capStr, modelFrame(bq));
            chk($sformatf("rand%0d FrameDone", f), endFd, 1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_channel.md
Name: hdlc_tx_channel

Overview:
- Serial transmit side of the HDLC link; it is the mirror of the receive channel.
- Accepts payload bytes through a one-byte valid/ready holding register and serializes them LSB first at one bit per Clk.
- Frames each sequence with opening and closing flags (0x7E) and inserts a 0 after every five consecutive data 1s.
- Generates the abort pattern (0xFE, LSB first) on request or on data underrun.

Parameters:
- FLAG, 8'h7E, flag byte sent LSB first (bit order 0,1,1,1,1,1,1,0).
- ABORT, 8'hFE, abort byte sent LSB first (bit order 0,1,1,1,1,1,1,1).

Ports:
- Clk  input  1  clock.
- Rst  input  1  asynchronous active-low reset.
- TxEN  input  1  channel enable; low forces IDLE.
- TxData  input  8  payload byte.
- TxValid  input  1  TxData/TxLast valid.
- TxLast  input  1  byte is the last of the frame; sampled with the byte.
- TxReady  output  1  holding register can accept a byte.
- TxAbort  input  1  request abort of the current frame.
- Tx  output  1  serial line bit (registered).
- Busy  output  1  state is not IDLE.
- FrameDone  output  1  1-cycle pulse, closing flag completed.
- Aborted  output  1  1-cycle pulse, abort pattern completed.
- Underrun  output  1  1-cycle pulse, abort was caused by an empty holding register.

Behaviour:
- Reset values: Tx=1, Busy=0, FrameDone=0, Aborted=0, Underrun=0, holding register empty, state IDLE, ones counter 0.
- Handshake:
  - TxReady = TxEN && !HoldFull && state!=ABORT. It is combinational from registers.
  - A byte is accepted on an edge where TxValid&&TxReady; TxData and TxLast are captured.
  - The shifter empties the holding register on the edge it loads. A new byte can be accepted from the next cycle (one-cycle bubble is allowed).
- States:
  - IDLE: Tx=1. If TxEN && HoldFull go to OPEN_FLAG.
  - OPEN_FLAG: 8 cycles shifting FLAG.
  - DATA: shift the loaded byte.
  - CLOSE_FLAG: 8 cycles shifting FLAG.
  - ABORT: 8 cycles shifting ABORT.
- Latency: byte accepted at edge E0 (in IDLE). Tx carries opening flag bit 0 after E1, flag bit i after E1+i, data bit 0 after E9.
- End of OPEN_FLAG and each data byte:
  - If HoldFull: load the held byte into DATA.
  - Else if the byte just sent had TxLast=1: go to CLOSE_FLAG.
  - Else: underrun. Go to ABORT and pulse Underrun on entry.
  - The end of OPEN_FLAG always finds HoldFull, because the start byte is held.
- Zero insertion (DATA only):
  - The ones counter increments on each transmitted data 1 and clears on a data 0.
  - When the counter reaches 5, the next cycle outputs an inserted 0, the bit index does not advance, and the counter clears.
  - The counter persists across byte boundaries within a frame.
  - The counter clears on entry to any flag or abort state.
  - A pending insertion at the byte's final bit is emitted before the byte-end decision.
- CLOSE_FLAG end:
  - Pulse FrameDone.
  - If HoldFull && TxEN, start a new OPEN_FLAG immediately (flags are never shared). Else go to IDLE (Tx=1).
- TxAbort:
  - Sampled high in OPEN_FLAG or DATA: the next edge enters ABORT from bit 0 and flushes the holding register.
  - Ignored in IDLE, CLOSE_FLAG and ABORT.
  - At ABORT end, pulse Aborted and go to IDLE.
- TxEN low in any state: the next edge enters IDLE, Tx=1, the holding register is flushed, and no pulses are generated.
- Simultaneous TxAbort and underrun on the same edge: ABORT is entered once, Underrun pulses, and a single Aborted pulse follows.
- Reset mid-operation immediately returns all state to the reset values; no partial pattern completes.

Test Plan:
- Single frame, byte 0x01 with TxLast=1, accepted at E0:
  - Tx after E1..E24 = 0111_1110, 1000_0000, 0111_1110; then Tx=1.
  - FrameDone pulses once; Busy falls after the closing flag.
- Byte 0xFF with TxLast:
  - Data field is 9 bits: 1,1,1,1,1,0,1,1,1.
  - The receive channel fed with Tx returns RxData=0xFF with no false FlagDetect or Abort.
- Two bytes 0xFF,0xFF back-to-back:
  - Second byte occupies 10 cycles: 1,1,0,1,1,1,1,1,0,1.
  - This confirms the ones counter spans bytes; TxReady handshake shows no gaps in Tx.
- Underrun: one byte 0x55 with TxLast=0 and no further TxValid:
  - After the data, Tx = 0,1,1,1,1,1,1,1.
  - Underrun pulses at ABORT entry; Aborted pulses at its end; then IDLE.
- TxAbort asserted mid-DATA (3rd data bit): the next 8 Tx bits are the ABORT pattern, the holding register is flushed (TxReady=1 afterwards), and Aborted pulses.
- Reset and TxEN mid-frame:
  - TxEN low mid-frame returns IDLE, Tx=1, and no FrameDone.
  - Rst asserted mid-data drives Tx=1, Busy=0 and all pulses 0 asynchronously.
  - After release, a new frame transmits correctly.
